// File: rtl/wb_pkg.sv
// ============================================================================
// wb_pkg : shared constants for the write-back stage (state codes, widths,
//          result-source selects).                               Rev 1.0
// ============================================================================
`default_nettype none

package wb_pkg;

  localparam int DEF_DATA_W      = 16;
  localparam int DEF_REG_AW      = 3;
  localparam int DEF_MEM_TIMEOUT = 15;

  localparam int               ST_W        = 1;
  localparam logic [ST_W-1:0]  ST_RUN      = 1'b0;
  localparam logic [ST_W-1:0]  ST_WAIT_MEM = 1'b1;

  localparam int               SRC_W    = 2;
  localparam logic [SRC_W-1:0] SRC_ALU  = 2'd0;
  localparam logic [SRC_W-1:0] SRC_MEM  = 2'd1;
  localparam logic [SRC_W-1:0] SRC_LINK = 2'd2;

endpackage

`default_nettype wire

// File: rtl/wb_timeout_counter.sv
// ============================================================================
// wb_timeout_counter : counts WAIT_MEM cycles; tc flags MEM_TIMEOUT-1.
//                                                                 Rev 1.0
// ============================================================================
`default_nettype none

module wb_timeout_counter
  import wb_pkg::*;
#(
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int               CNT_W  = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(MEM_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == TC_VAL);

endmodule

`default_nettype wire

// File: rtl/wb_stage.sv
// ============================================================================
// wb_stage : MEM/WB pipeline register and write-back sequencer.
//            Optional macro WB_R0_HARDWIRED_EN suppresses writes to r0. Rev 1.0
// ============================================================================
`default_nettype none

module wb_stage
  import wb_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int REG_AW      = DEF_REG_AW,
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in_regWrite,
  input  logic              in_memToReg,
  input  logic              in_link,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [DATA_W-1:0] in_pc4,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] WB,
  output logic [REG_AW-1:0] WriteRegister,
  output logic              regWrite,
  output logic              stall,
  output logic              mem_err,
  output logic [15:0]       retired
);

  logic [ST_W-1:0]   state_q, state_d;
  logic [REG_AW-1:0] pend_rd_q, pend_rd_d;
  logic              pend_we_q, pend_we_d;
  logic [DATA_W-1:0] wb_q, wb_d;
  logic [REG_AW-1:0] waddr_q, waddr_d;
  logic              we_q, we_d;
  logic              mem_err_q, mem_err_d;
  logic [15:0]       retired_q, retired_d;

  logic              is_load;
  logic              complete;
  logic [SRC_W-1:0]  src_sel;
  logic [REG_AW-1:0] cmp_rd;
  logic              cmp_we;
  logic [DATA_W-1:0] result;
  logic              r0_ok;
  logic              cnt_clear;
  logic              cnt_en;
  logic              cnt_tc;

  // A link instruction never waits on memory, even if memToReg is also set.
  assign is_load = in_memToReg & ~in_link;

  wb_timeout_counter #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_timeout (
    .clock  (clock),
    .reset  (reset),
    .clear  (cnt_clear),
    .enable (cnt_en),
    .tc     (cnt_tc)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:      if (in_valid && is_load) state_d = ST_WAIT_MEM;
      ST_WAIT_MEM: if (mem_rvalid || cnt_tc) state_d = ST_RUN;
      default:     state_d = ST_RUN;
    endcase
  end

  always_comb begin
    complete  = 1'b0;
    src_sel   = SRC_ALU;
    cmp_rd    = in_rd;
    cmp_we    = in_regWrite;
    pend_rd_d = pend_rd_q;
    pend_we_d = pend_we_q;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;
    mem_err_d = mem_err_q;
    case (state_q)
      ST_RUN: begin
        if (in_valid) begin
          if (is_load) begin
            pend_rd_d = in_rd;
            pend_we_d = in_regWrite;
            cnt_clear = 1'b1;
          end else begin
            complete = 1'b1;
            src_sel  = in_link ? SRC_LINK : SRC_ALU;
          end
        end
      end
      ST_WAIT_MEM: begin
        // Read data wins over the timeout on the terminal cycle.
        if (mem_rvalid) begin
          complete = 1'b1;
          src_sel  = SRC_MEM;
          cmp_rd   = pend_rd_q;
          cmp_we   = pend_we_q;
        end else if (cnt_tc) begin
          mem_err_d = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    case (src_sel)
      SRC_LINK: result = in_pc4;
      SRC_MEM:  result = mem_rdata;
      default:  result = in_alu;
    endcase
  end

`ifdef WB_R0_HARDWIRED_EN
  assign r0_ok = (cmp_rd != '0);
`else
  assign r0_ok = 1'b1;
`endif

  assign wb_d      = complete ? result : wb_q;
  assign waddr_d   = complete ? cmp_rd : waddr_q;
  assign we_d      = complete & cmp_we & r0_ok;
  assign retired_d = complete ? (retired_q + 16'd1) : retired_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pend_rd_q <= '0;
      pend_we_q <= 1'b0;
      wb_q      <= '0;
      waddr_q   <= '0;
      we_q      <= 1'b0;
      mem_err_q <= 1'b0;
      retired_q <= '0;
    end else begin
      pend_rd_q <= pend_rd_d;
      pend_we_q <= pend_we_d;
      wb_q      <= wb_d;
      waddr_q   <= waddr_d;
      we_q      <= we_d;
      mem_err_q <= mem_err_d;
      retired_q <= retired_d;
    end
  end

  assign WB            = wb_q;
  assign WriteRegister = waddr_q;
  assign regWrite      = we_q;
  assign stall         = (state_q == ST_WAIT_MEM);
  assign mem_err       = mem_err_q;
  assign retired       = retired_q;

endmodule

`default_nettype wire
